// File: rtl/multi_ch_lat_ram_if.sv
// Shared channel-state type and the per-channel request/response bundle
// used between requesters (master) and the latency RAM (slave).
package multi_ch_lat_ram_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

interface multi_ch_lat_ram_if #(
  parameter int NCH = 2
);
  import multi_ch_lat_ram_pkg::*;

  logic [NCH-1:0] ramREN;
  logic [NCH-1:0] ramWEN;
  logic [31:0]    ramaddr  [NCH];
  logic [31:0]    ramstore [NCH];
  logic [3:0]     ramBEN   [NCH];
  logic [31:0]    ramload  [NCH];
  ramstate_t      ramstate [NCH];

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore, ramBEN,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore, ramBEN,
    output ramload, ramstate
  );
endinterface

// File: rtl/multi_ch_lat_ram.sv
// Multi-channel word RAM with a fixed access latency: one round-robin grant
// at a time, the granted channel waits LAT cycles before it may access.
module multi_ch_lat_ram
  import multi_ch_lat_ram_pkg::*;
#(
  parameter int          NCH   = 2,
  parameter int          DEPTH = 16384,
  parameter int          LAT   = 6,
  parameter logic [31:0] BAD   = 32'hBAD1BAD1
) (
  input  logic             CLK,
  input  logic             nRST,
  multi_ch_lat_ram_if.slave bus
);
  localparam int             AW      = $clog2(DEPTH);
  localparam int             IDW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [3:0]     LATC    = 4'(LAT);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NCH - 1);

  logic [31:0] r_mem [DEPTH] = '{default: 32'h0};

  logic           r_gnt_valid;
  logic [IDW-1:0] r_gnt_id;
  logic [3:0]     r_count;
  logic [AW-1:0]  r_idx;
  logic [1:0]     r_mode;

  logic           w_gnt_valid_next;
  logic [IDW-1:0] w_gnt_id_next;
  logic [3:0]     w_count_next;
  logic [AW-1:0]  w_idx_next;
  logic [1:0]     w_mode_next;

  logic [NCH-1:0] w_free;
  logic [NCH-1:0] w_err;
  logic [NCH-1:0] w_valid;
  logic [NCH-1:0] w_match;
  logic [NCH-1:0] w_access;
  logic [NCH-1:0] w_unused_lo;
  logic [AW-1:0]  w_idx     [NCH];
  logic [1:0]     w_mode_ch [NCH];

  logic           w_we;
  logic [31:0]    w_wdata;
  logic [3:0]     w_ben;
  logic [31:0]    w_rd_data;
  logic           w_unused;
  int             w_scan;
  logic [IDW-1:0] w_scan_id;
  logic           w_found;

  // Per-channel request decode and response generation.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic w_oor;
    if (AW + 2 < 32) begin : g_hi
      assign w_oor = |bus.ramaddr[gi][31:AW+2];
    end else begin : g_nohi
      assign w_oor = 1'b0;
    end

    assign w_idx[gi]       = bus.ramaddr[gi][AW+1:2];
    assign w_mode_ch[gi]   = {bus.ramREN[gi], bus.ramWEN[gi]};
    assign w_free[gi]      = ~bus.ramREN[gi] & ~bus.ramWEN[gi];
    assign w_err[gi]       = ~w_free[gi] & ((bus.ramREN[gi] & bus.ramWEN[gi]) | w_oor);
    assign w_valid[gi]     = ~w_free[gi] & ~w_err[gi];
    assign w_match[gi]     = (w_idx[gi] == r_idx) && (w_mode_ch[gi] == r_mode);
    // ACCESS only for the exact request the wait was counted for.
    assign w_access[gi]    = nRST & w_valid[gi] & r_gnt_valid & (r_gnt_id == IDW'(gi))
                           & w_match[gi] & (r_count == LATC);
    assign w_unused_lo[gi] = ^bus.ramaddr[gi][1:0];

    assign bus.ramstate[gi] = (!nRST || w_free[gi]) ? FREE   :
                              w_err[gi]             ? ERROR  :
                              w_access[gi]          ? ACCESS : BUSY;
    assign bus.ramload[gi]  = (w_access[gi] && bus.ramREN[gi]) ? w_rd_data : BAD;
  end

  assign w_unused = ^w_unused_lo;

  // The array is single-ported: reads and writes both use the held index.
  assign w_rd_data = r_mem[r_idx];
  assign w_we      = |(w_access & bus.ramWEN);
  assign w_wdata   = bus.ramstore[r_gnt_id];
  assign w_ben     = bus.ramBEN[r_gnt_id];

  always_ff @(posedge CLK) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_ben[b]) begin
          r_mem[r_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= LAST_ID;
      r_count     <= 4'd0;
      r_idx       <= '0;
      r_mode      <= 2'b00;
    end else begin
      r_gnt_valid <= w_gnt_valid_next;
      r_gnt_id    <= w_gnt_id_next;
      r_count     <= w_count_next;
      r_idx       <= w_idx_next;
      r_mode      <= w_mode_next;
    end
  end

  always_comb begin
    w_gnt_valid_next = r_gnt_valid;
    w_gnt_id_next    = r_gnt_id;
    w_count_next     = r_count;
    w_idx_next       = r_idx;
    w_mode_next      = r_mode;
    w_scan           = 0;
    w_scan_id        = '0;
    w_found          = 1'b0;
    if (!r_gnt_valid) begin
      // Round-robin: start just after the most recently granted channel.
      for (int k = 0; k < NCH; k++) begin
        w_scan = int'(r_gnt_id) + 1 + k;
        if (w_scan >= NCH) begin
          w_scan = w_scan - NCH;
        end
        w_scan_id = IDW'(w_scan);
        if (!w_found && w_valid[w_scan_id]) begin
          w_found          = 1'b1;
          w_gnt_valid_next = 1'b1;
          w_gnt_id_next    = w_scan_id;
          w_idx_next       = w_idx[w_scan_id];
          w_mode_next      = w_mode_ch[w_scan_id];
          w_count_next     = 4'd0;
        end
      end
    end else if (!w_valid[r_gnt_id]) begin
      w_gnt_valid_next = 1'b0;
    end else if (!w_match[r_gnt_id]) begin
      w_idx_next   = w_idx[r_gnt_id];
      w_mode_next  = w_mode_ch[r_gnt_id];
      w_count_next = 4'd0;
    end else if (r_count != LATC) begin
      w_count_next = r_count + 4'd1;
    end
  end
endmodule
